mem_access_stage: RTL and testbench

//   EX/MEM pipeline register plus memory-stage access controller for the pipelined LEGv8 core.

---
 rtl/mem_access_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register and memory-stage access controller for the pipelined LEGv8 core.
// Holds the execute results, runs a variable-latency req/ack data-memory access and resolves branches.
module mem_access_stage #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic         zero_E,
  input  logic         Branch_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         RegWrite_E,
  input  logic         MemtoReg_E,
  input  logic [4:0]   writeReg_E,
  input  logic         memAck,
  input  logic [N-1:0] memRdata,
  output logic         memReq,
  output logic         memWe,
  output logic [N-1:0] memAddr,
  output logic [N-1:0] memWdata,
  output logic         stall_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic [4:0]   writeReg_M,
  output logic         RegWrite_M,
  output logic         MemtoReg_M,
  output logic         valid_M,
  output logic         misalign_M,
  output logic         busErr_M,
  output logic [1:0]   state_dbg_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic [N-1:0]  rdata_q;

  logic          valid_q;
  logic [N-1:0]  pcbranch_q;
  logic [N-1:0]  alu_q;
  logic [N-1:0]  wdata_q;
  logic          zero_q;
  logic          branch_q;
  logic          memread_q;
  logic          memwrite_q;
  logic          regwrite_q;
  logic          memtoreg_q;
  logic [4:0]    wreg_q;

  logic          mem_op;
  logic          aligned;
  logic          timeout_hit;

  assign mem_op      = valid_q & (memread_q | memwrite_q);
  assign aligned     = (alu_q[2:0] == 3'b000);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // Memory handshake: memReq is high for exactly the BUSY cycles; address, data and
  // write-enable come straight from the held M registers, so they stay stable until the
  // edge where memAck is sampled high. memAck/memRdata are ignored outside BUSY.
  assign memReq   = (state_q == S_BUSY);
  assign memWe    = memReq & memwrite_q;
  assign memAddr  = alu_q;
  assign memWdata = wdata_q;

  assign stall_M    = ((state_q == S_IDLE) & mem_op & aligned) | (state_q == S_BUSY);
  assign misalign_M = mem_op & ~aligned;
  assign busErr_M   = (state_q == S_DONE) & err_q;
  assign RegWrite_M = regwrite_q & ~misalign_M & ~busErr_M;
  assign PCSrc_M    = branch_q & zero_q & valid_q;

  assign PCBranch_M  = pcbranch_q;
  assign aluResult_M = alu_q;
  assign readData_M  = rdata_q;
  assign writeReg_M  = wreg_q;
  assign MemtoReg_M  = memtoreg_q;
  assign valid_M     = valid_q;
  assign state_dbg_o = state_q;

  // EX/MEM register: advances whenever the stage is not stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pcbranch_q <= '0;
      alu_q      <= '0;
      wdata_q    <= '0;
      zero_q     <= 1'b0;
      branch_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      wreg_q     <= '0;
    end else if (!stall_M) begin
      valid_q    <= valid_E;
      pcbranch_q <= PCBranch_E;
      alu_q      <= aluResult_E;
      wdata_q    <= writeData_E;
      zero_q     <= zero_E;
      branch_q   <= Branch_E;
      memread_q  <= MemRead_E;
      memwrite_q <= MemWrite_E;
      regwrite_q <= RegWrite_E;
      memtoreg_q <= MemtoReg_E;
      wreg_q     <= writeReg_E;
    end
  end

  // Access FSM; an ack in the same cycle as the timeout wins over the error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_op && aligned) begin
            state_q <= S_BUSY;
            cnt_q   <= '0;
          end
        end
        S_BUSY: begin
          if (memAck) begin
            if (memread_q) rdata_q <= memRdata;
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus a random back-to-back stream,
// checked against a transaction-level model of occupancy, handshake and results.
module tb_mem_access_stage;

  localparam int N  = 64;
  localparam int TO = 4;

  typedef struct {
    logic         valid;
    logic [N-1:0] pcb;
    logic [N-1:0] alu;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         zero;
    logic         br;
    logic         rd;
    logic         wr;
    logic         rw;
    logic         m2r;
    logic [4:0]   wreg;
    int           ack_at;
  } instr_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_E, zero_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
  logic [N-1:0] PCBranch_E, aluResult_E, writeData_E, memRdata;
  logic [4:0]   writeReg_E;
  logic         memAck;
  logic         memReq, memWe, stall_M, PCSrc_M, RegWrite_M, MemtoReg_M, valid_M;
  logic         misalign_M, busErr_M;
  logic [N-1:0] memAddr, memWdata, PCBranch_M, aluResult_M, readData_M;
  logic [4:0]   writeReg_M;
  logic [1:0]   state_dbg;

  int           passed = 0;
  int           total  = 0;
  logic [N-1:0] exp_rdata;
  logic [N-1:0] exp_q[$];

  mem_access_stage #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .PCBranch_E(PCBranch_E),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .zero_E(zero_E),
    .Branch_E(Branch_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .writeReg_E(writeReg_E),
    .memAck(memAck), .memRdata(memRdata), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWdata(memWdata), .stall_M(stall_M), .PCSrc_M(PCSrc_M),
    .PCBranch_M(PCBranch_M), .aluResult_M(aluResult_M), .readData_M(readData_M),
    .writeReg_M(writeReg_M), .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M),
    .valid_M(valid_M), .misalign_M(misalign_M), .busErr_M(busErr_M),
    .state_dbg_o(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic instr_t mk(input logic v, input logic rd, input logic wr, input logic br,
                                input logic z, input logic [N-1:0] alu, input logic [N-1:0] wd,
                                input logic [N-1:0] rdat, input int ack_at);
    instr_t t;
    t.valid = v; t.rd = rd; t.wr = wr; t.br = br; t.zero = z;
    t.alu = alu; t.wdata = wd; t.rdata = rdat; t.ack_at = ack_at;
    t.pcb = rnd64();
    t.rw = ~wr & ~br;
    t.m2r = rd;
    t.wreg = 5'($urandom_range(0, 31));
    return t;
  endfunction

  function automatic instr_t rand_instr();
    int kind;
    logic [N-1:0] a;
    kind = $urandom_range(0, 3);
    a = rnd64();
    if ($urandom_range(0, 4) != 0) a[2:0] = 3'b000;
    return mk(($urandom_range(0, 7) != 0), kind == 1, kind == 2, kind == 3,
              1'($urandom_range(0, 1)), a, rnd64(), rnd64(), $urandom_range(0, TO + 1));
  endfunction

  function automatic instr_t bubble();
    return mk(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1,
              rnd64(), rnd64(), rnd64(), 0);
  endfunction

  // Driver tasks
  task automatic drive_e(input instr_t t);
    valid_E = t.valid; PCBranch_E = t.pcb; aluResult_E = t.alu; writeData_E = t.wdata;
    zero_E = t.zero; Branch_E = t.br; MemRead_E = t.rd; MemWrite_E = t.wr;
    RegWrite_E = t.rw; MemtoReg_E = t.m2r; writeReg_E = t.wreg;
  endtask

  // cur must be on the E inputs with M free at the next edge; nxt is presented after capture.
  task automatic run(input instr_t cur, input instr_t nxt);
    logic memop, mis, err;
    int b;
    logic [N-1:0] exp_alu;
    exp_q.push_back(cur.alu);
    total++; if (stall_M !== 1'b0) $display("FAIL pre_capture_stall got %b exp 0", stall_M); else passed++;
    @(posedge clk); #1;
    drive_e(nxt);
    memAck = 1'($urandom_range(0, 1));
    memRdata = rnd64();
    exp_alu = exp_q.pop_front();
    memop = cur.valid & (cur.rd | cur.wr);
    mis = memop & (cur.alu[2:0] != 3'b000);
    total++; if (valid_M !== cur.valid) $display("FAIL valid_M got %b exp %b", valid_M, cur.valid); else passed++;
    total++; if (aluResult_M !== exp_alu) $display("FAIL aluResult_M got %h exp %h", aluResult_M, exp_alu); else passed++;
    total++; if (PCBranch_M !== cur.pcb) $display("FAIL PCBranch_M got %h exp %h", PCBranch_M, cur.pcb); else passed++;
    total++; if (writeReg_M !== cur.wreg) $display("FAIL writeReg_M got %h exp %h", writeReg_M, cur.wreg); else passed++;
    total++; if (MemtoReg_M !== cur.m2r) $display("FAIL MemtoReg_M got %b exp %b", MemtoReg_M, cur.m2r); else passed++;
    total++; if (PCSrc_M !== (cur.br & cur.zero & cur.valid)) $display("FAIL PCSrc_M got %b exp %b", PCSrc_M, cur.br & cur.zero & cur.valid); else passed++;
    total++; if (misalign_M !== mis) $display("FAIL misalign_M got %b exp %b", misalign_M, mis); else passed++;
    total++; if (RegWrite_M !== (cur.rw & ~mis)) $display("FAIL RegWrite_M_first got %b exp %b", RegWrite_M, cur.rw & ~mis); else passed++;
    total++; if (memReq !== 1'b0) $display("FAIL memReq_first got %b exp 0", memReq); else passed++;
    total++; if (stall_M !== (memop & ~mis)) $display("FAIL stall_first got %b exp %b", stall_M, memop & ~mis); else passed++;
    total++; if (readData_M !== exp_rdata) $display("FAIL readData_first got %h exp %h", readData_M, exp_rdata); else passed++;
    if (memop && !mis) begin
      err = !(cur.ack_at >= 1 && cur.ack_at <= TO);
      b = err ? TO : cur.ack_at;
      for (int k = 1; k <= b; k++) begin
        @(posedge clk); #1;
        memAck = (k == cur.ack_at);
        memRdata = (k == cur.ack_at) ? cur.rdata : rnd64();
        total++; if (memReq !== 1'b1) $display("FAIL busy_memReq cyc %0d got %b exp 1", k, memReq); else passed++;
        total++; if (stall_M !== 1'b1) $display("FAIL busy_stall cyc %0d got %b exp 1", k, stall_M); else passed++;
        total++; if (memWe !== cur.wr) $display("FAIL busy_memWe cyc %0d got %b exp %b", k, memWe, cur.wr); else passed++;
        total++; if (memAddr !== cur.alu) $display("FAIL busy_memAddr cyc %0d got %h exp %h", k, memAddr, cur.alu); else passed++;
        total++; if (memWdata !== cur.wdata) $display("FAIL busy_memWdata cyc %0d got %h exp %h", k, memWdata, cur.wdata); else passed++;
        total++; if (busErr_M !== 1'b0) $display("FAIL busy_busErr cyc %0d got %b exp 0", k, busErr_M); else passed++;
      end
      @(posedge clk); #1;
      memAck = 1'($urandom_range(0, 1));
      memRdata = rnd64();
      if (err) exp_rdata = '0;
      else if (cur.rd) exp_rdata = cur.rdata;
      total++; if (memReq !== 1'b0) $display("FAIL done_memReq got %b exp 0", memReq); else passed++;
      total++; if (memWe !== 1'b0) $display("FAIL done_memWe got %b exp 0", memWe); else passed++;
      total++; if (stall_M !== 1'b0) $display("FAIL done_stall got %b exp 0", stall_M); else passed++;
      total++; if (busErr_M !== err) $display("FAIL done_busErr got %b exp %b", busErr_M, err); else passed++;
      total++; if (readData_M !== exp_rdata) $display("FAIL done_readData got %h exp %h", readData_M, exp_rdata); else passed++;
      total++; if (RegWrite_M !== (cur.rw & ~err)) $display("FAIL done_RegWrite got %b exp %b", RegWrite_M, cur.rw & ~err); else passed++;
      total++; if (aluResult_M !== cur.alu) $display("FAIL done_aluResult got %h exp %h", aluResult_M, cur.alu); else passed++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    memAck = 1'b1;
    memRdata = rnd64();
    drive_e(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h40, rnd64(), rnd64(), 1));
    repeat (3) @(posedge clk);
    #1;
    total++; if (valid_M !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_M); else passed++;
    total++; if (aluResult_M !== '0) $display("FAIL reset_alu got %h exp 0", aluResult_M); else passed++;
    total++; if (PCBranch_M !== '0) $display("FAIL reset_pcb got %h exp 0", PCBranch_M); else passed++;
    total++; if (readData_M !== '0) $display("FAIL reset_rdata got %h exp 0", readData_M); else passed++;
    total++; if (memReq !== 1'b0) $display("FAIL reset_memReq got %b exp 0", memReq); else passed++;
    total++; if (stall_M !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall_M); else passed++;
    total++; if (busErr_M !== 1'b0) $display("FAIL reset_busErr got %b exp 0", busErr_M); else passed++;
    total++; if ({RegWrite_M, MemtoReg_M, PCSrc_M, misalign_M} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {RegWrite_M, MemtoReg_M, PCSrc_M, misalign_M}); else passed++;
    reset = 1'b0;
    memAck = 1'b0;
    exp_rdata = '0;
    drive_e(bubble());
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    instr_t a;
    a = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h10, rnd64(), rnd64(), 0);
    drive_e(a); run(a, bubble());
  endtask

  task automatic test_load();
    instr_t a;
    a = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h40, rnd64(), 64'hDEAD, 2);
    drive_e(a); run(a, bubble());
  endtask

  task automatic test_store();
    instr_t a;
    a = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h48, 64'h1234, rnd64(), 3);
    drive_e(a); run(a, bubble());
  endtask

  task automatic test_misalign();
    instr_t a;
    a = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h43, rnd64(), rnd64(), 1);
    drive_e(a); run(a, bubble());
  endtask

  task automatic test_branch();
    instr_t a, c;
    a = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rnd64(), rnd64(), rnd64(), 0);
    c = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, rnd64(), rnd64(), rnd64(), 0);
    drive_e(a); run(a, c); run(c, bubble());
  endtask

  task automatic test_timeout();
    instr_t a, c;
    a = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h80, rnd64(), rnd64(), 0);
    c = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h88, rnd64(), 64'hBEEF, TO);
    drive_e(a); run(a, c); run(c, bubble());
  endtask

  task automatic test_reset_busy();
    drive_e(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h90, rnd64(), rnd64(), 0));
    memAck = 1'b0;
    @(posedge clk); #1;
    drive_e(bubble());
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (memReq !== 1'b1) $display("FAIL rb_busy2_memReq got %b exp 1", memReq); else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    memAck = 1'b1;
    memRdata = rnd64();
    total++; if (memReq !== 1'b0) $display("FAIL rb_memReq got %b exp 0", memReq); else passed++;
    total++; if (valid_M !== 1'b0) $display("FAIL rb_valid got %b exp 0", valid_M); else passed++;
    total++; if (stall_M !== 1'b0) $display("FAIL rb_stall got %b exp 0", stall_M); else passed++;
    @(posedge clk); #1;
    memAck = 1'b0;
    total++; if (memReq !== 1'b0) $display("FAIL rb_late_memReq got %b exp 0", memReq); else passed++;
    total++; if (readData_M !== '0) $display("FAIL rb_late_rdata got %h exp 0", readData_M); else passed++;
    total++; if (busErr_M !== 1'b0) $display("FAIL rb_late_busErr got %b exp 0", busErr_M); else passed++;
    exp_rdata = '0;
  endtask

  task automatic test_back_to_back();
    instr_t s[$];
    for (int i = 0; i < 40; i++) s.push_back(rand_instr());
    s.push_back(bubble());
    drive_e(s[0]);
    for (int i = 0; i < 40; i++) run(s[i], s[i + 1]);
  endtask

  initial begin
    memAck = 1'b0;
    memRdata = '0;
    exp_rdata = '0;
    test_reset();
    test_add();
    test_load();
    test_store();
    test_misalign();
    test_branch();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
